johnson_decoder: RTL and testbench
==================================

JOHNSON_DECODER -- requirements
Module: johnson_decoder

Interface
REQ-001 Parameter: LOCK_COUNT, default 4, number of consecutive legal +1 steps required to reach LOCKED (range 1..15).
REQ-002 Parameter: ALLOW_HOLD, default 1; when 1, a repeated code is accepted as a hold, and when 0 it is a step error.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: clear  input  1  synchronous clear of counters, sticky flag and FSM.
REQ-006 Port: code_in  input  4  sampled Johnson code, bit 3 MSB.
REQ-007 Port: in_valid  input  1  code_in is sampled on this rising edge.
REQ-008 Port: idx  output  3  decoded index of the last legal sample.
REQ-009 Port: out_valid  output  1  one-cycle pulse: idx and flags refer to the sample taken on the previous edge.
REQ-010 Port: code_err  output  1  one-cycle pulse: the last sample was not a legal Johnson code.
REQ-011 Port: step_err  output  1  one-cycle pulse: the last sample was legal but not an allowed successor.
REQ-012 Port: locked  output  1  level: FSM is in LOCKED.
REQ-013 Port: sticky_err  output  1  set by any code_err or step_err; cleared only by rst or clear.
REQ-014 Port: wrap_cnt  output  8  count of 7->0 steps while LOCKED; wraps modulo 256.
REQ-015 Port: err_cnt  output  8  count of code_err plus step_err events; saturates at 255.

Function
REQ-016 Legal codes map to idx as follows: 0000->0, 0001->1, 0011->2, 0111->3, 1111->4, 1110->5, 1100->6, 1000->7; the other 8 codes are illegal.
REQ-017 Allowed successor: idx = (prev+1) mod 8; also idx = prev when ALLOW_HOLD=1.
REQ-018 All outputs are registered; a sample taken on edge N produces out_valid and its flags after edge N, i.e. 1-cycle latency.
REQ-019 With in_valid=0, the FSM, prev, counters and idx hold, and out_valid/code_err/step_err are 0.
REQ-020 The FSM has three states: IDLE (no reference), TRACK (reference held, good_cnt < LOCK_COUNT) and LOCKED.
REQ-021 IDLE transitions:
  - legal sample: -> TRACK, prev=idx, good_cnt=0, no error.
  - illegal sample: stays IDLE, code_err pulses.
REQ-022 TRACK transitions:
  - +1 step: good_cnt increments; when it reaches LOCK_COUNT, -> LOCKED.
  - allowed hold: no change to good_cnt.
  - other legal code: step_err pulses, good_cnt=0, prev=new idx.
  - illegal code: code_err pulses, -> IDLE.
REQ-023 LOCKED transitions:
  - +1 step or allowed hold: stays LOCKED.
  - other legal code: step_err pulses, -> TRACK, good_cnt=0, prev=new idx.
  - illegal code: code_err pulses, -> IDLE.
REQ-024 On an illegal sample, idx holds its previous value while out_valid still pulses.
REQ-025 wrap_cnt increments only when the FSM was LOCKED before the sample and the sample steps prev=7 -> idx=0.
REQ-026 code_err and step_err are never asserted in the same cycle.
REQ-027 err_cnt increments by 1 per error event and holds at 255.
REQ-028 clear with in_valid in the same cycle:
  - clear wins: the sample is discarded, no pulses are generated.
  - FSM -> IDLE; wrap_cnt, err_cnt and sticky_err -> 0; idx holds.

Reset
REQ-029 While rst=1, regardless of clk:
  - idx=0, out_valid=0, code_err=0, step_err=0, locked=0, sticky_err=0, wrap_cnt=0, err_cnt=0.
  - FSM=IDLE, good_cnt=0, prev=0.
REQ-030 Assertion of rst mid-sequence aborts tracking immediately; after deassertion the block requires a fresh legal sample plus LOCK_COUNT +1 steps before locked=1.

Verification
REQ-031 Lock: with defaults, apply the valid sequence 1000,0000,0001,0011,0111 -> idx 7,0,1,2,3; locked=1 after the 5th sample's output cycle; no errors.
REQ-032 Wrap: while locked, run 16 full cycles of the 8 codes -> wrap_cnt=16, err_cnt=0, sticky_err=0.
REQ-033 Illegal code: while locked, apply 0101 -> code_err pulse, locked=0, idx unchanged, err_cnt+1, sticky_err=1.
REQ-034 Skip step: while locked at idx 2, apply 1111 -> step_err, locked=0, idx=4; four further +1 steps -> locked=1.
REQ-035 Hold/valid gaps: repeat a code and insert in_valid=0 cycles:
  - ALLOW_HOLD=1: no error, lock holds.
  - ALLOW_HOLD=0: the repeat gives step_err.
REQ-036 Async reset and clear:
  - rst pulsed between clock edges while locked: all outputs are 0 before the next edge.
  - clear together with an illegal sample: no code_err, counters are 0.

Source files
------------

// File: rtl/johnson_decoder.sv
// -----------------------------------------------------------------------------
// johnson_decoder
//   Decodes a 4-bit Johnson code stream into a 3-bit index. A three-state FSM
//   (IDLE/TRACK/LOCKED) reaches LOCKED after LOCK_COUNT consecutive +1 steps.
//   It reports illegal codes and illegal successors as one-cycle pulses, and
//   keeps a sticky error flag, a wrap counter and a saturating error counter.
//   All outputs are registered, so each sample has one cycle of latency.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   clear      in   synchronous clear of FSM, counters and sticky flag
//   code_in    in   [3:0] Johnson code, bit 3 MSB
//   in_valid   in   code_in is sampled on this edge
//   idx        out  [2:0] index of the last legal sample
//   out_valid  out  pulse: outputs refer to the previous sample
//   code_err   out  pulse: previous sample was not a legal Johnson code
//   step_err   out  pulse: previous sample was legal but not an allowed successor
//   locked     out  FSM is in LOCKED
//   sticky_err out  set by any error; cleared by rst or clear
//   wrap_cnt   out  [7:0] count of 7->0 steps while locked, modulo 256
//   err_cnt    out  [7:0] count of error events, saturating at 255
// -----------------------------------------------------------------------------
module johnson_decoder #(
  parameter int LOCK_COUNT = 4,
  parameter int ALLOW_HOLD = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic [3:0] code_in,
  input  logic       in_valid,
  output logic [2:0] idx,
  output logic       out_valid,
  output logic       code_err,
  output logic       step_err,
  output logic       locked,
  output logic       sticky_err,
  output logic [7:0] wrap_cnt,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_e;

  localparam logic [3:0] LockN = 4'(LOCK_COUNT);

  state_e     state_q, state_d;
  logic [2:0] prev_q, prev_d;
  logic [3:0] good_q, good_d;
  logic [2:0] idx_q, idx_d;
  logic       out_valid_q, out_valid_d;
  logic       code_err_q, code_err_d;
  logic       step_err_q, step_err_d;
  logic       sticky_q, sticky_d;
  logic [7:0] wrap_q, wrap_d;
  logic [7:0] err_q, err_d;

  logic       dec_legal;
  logic [2:0] dec_idx;
  logic       is_step;
  logic       is_hold;

  // Johnson code to index; the eight remaining codes are illegal.
  always_comb begin
    dec_legal = 1'b1;
    dec_idx   = 3'd0;
    case (code_in)
      4'b0000: dec_idx = 3'd0;
      4'b0001: dec_idx = 3'd1;
      4'b0011: dec_idx = 3'd2;
      4'b0111: dec_idx = 3'd3;
      4'b1111: dec_idx = 3'd4;
      4'b1110: dec_idx = 3'd5;
      4'b1100: dec_idx = 3'd6;
      4'b1000: dec_idx = 3'd7;
      default: dec_legal = 1'b0;
    endcase
  end

  assign is_step = (dec_idx == 3'(prev_q + 3'd1));
  assign is_hold = (ALLOW_HOLD != 0) && (dec_idx == prev_q);

  // NOTE: every signal gets a default before any branch so that no path
  // leaves it unassigned; otherwise a latch would be inferred.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    good_d      = good_q;
    idx_d       = idx_q;
    out_valid_d = 1'b0;
    code_err_d  = 1'b0;
    step_err_d  = 1'b0;
    sticky_d    = sticky_q;
    wrap_d      = wrap_q;
    err_d       = err_q;

    if (clear) begin
      // A sample that arrives with clear is discarded; idx keeps its value.
      state_d  = IDLE;
      prev_d   = 3'd0;
      good_d   = 4'd0;
      sticky_d = 1'b0;
      wrap_d   = 8'd0;
      err_d    = 8'd0;
    end else if (in_valid) begin
      out_valid_d = 1'b1;
      if (!dec_legal) begin
        // idx holds; every state falls back to IDLE.
        code_err_d = 1'b1;
        state_d    = IDLE;
        good_d     = 4'd0;
      end else begin
        idx_d = dec_idx;
        case (state_q)
          IDLE: begin
            state_d = TRACK;
            prev_d  = dec_idx;
            good_d  = 4'd0;
          end
          TRACK: begin
            if (is_step) begin
              prev_d = dec_idx;
              good_d = good_q + 4'd1;
              if (good_d == LockN) state_d = LOCKED;
            end else if (!is_hold) begin
              step_err_d = 1'b1;
              prev_d     = dec_idx;
              good_d     = 4'd0;
            end
          end
          LOCKED: begin
            if (is_step) begin
              prev_d = dec_idx;
              if (prev_q == 3'd7) wrap_d = wrap_q + 8'd1;
            end else if (!is_hold) begin
              step_err_d = 1'b1;
              state_d    = TRACK;
              prev_d     = dec_idx;
              good_d     = 4'd0;
            end
          end
          default: state_d = IDLE;
        endcase
      end

      if (code_err_d || step_err_d) begin
        sticky_d = 1'b1;
        if (err_q != 8'hFF) err_d = err_q + 8'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      prev_q      <= 3'd0;
      good_q      <= 4'd0;
      idx_q       <= 3'd0;
      out_valid_q <= 1'b0;
      code_err_q  <= 1'b0;
      step_err_q  <= 1'b0;
      sticky_q    <= 1'b0;
      wrap_q      <= 8'd0;
      err_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      good_q      <= good_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      code_err_q  <= code_err_d;
      step_err_q  <= step_err_d;
      sticky_q    <= sticky_d;
      wrap_q      <= wrap_d;
      err_q       <= err_d;
    end
  end

  assign idx        = idx_q;
  assign out_valid  = out_valid_q;
  assign code_err   = code_err_q;
  assign step_err   = step_err_q;
  assign locked     = (state_q == LOCKED);
  assign sticky_err = sticky_q;
  assign wrap_cnt   = wrap_q;
  assign err_cnt    = err_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// -----------------------------------------------------------------------------
// tb_johnson_decoder
//   Directed bench for johnson_decoder. A table of single-sample vectors covers
//   lock, holds, gaps, illegal codes, skips and clear. Hand-written sequences
//   cover err_cnt saturation, wrap counting, ALLOW_HOLD=0 and async reset.
// -----------------------------------------------------------------------------
module tb_johnson_decoder;

  logic       clk;
  logic       rst;
  logic       clear;
  logic [3:0] code_in;
  logic       in_valid;

  logic [2:0] idx;
  logic       out_valid, code_err, step_err, locked, sticky_err;
  logic [7:0] wrap_cnt, err_cnt;

  logic [2:0] idx2;
  logic       out_valid2, code_err2, step_err2, locked2, sticky_err2;
  logic [7:0] wrap_cnt2, err_cnt2;

  int checks   = 0;
  int failures = 0;

  johnson_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .code_in   (code_in),
    .in_valid  (in_valid),
    .idx       (idx),
    .out_valid (out_valid),
    .code_err  (code_err),
    .step_err  (step_err),
    .locked    (locked),
    .sticky_err(sticky_err),
    .wrap_cnt  (wrap_cnt),
    .err_cnt   (err_cnt)
  );

  johnson_decoder #(.LOCK_COUNT(4), .ALLOW_HOLD(0)) dut_nohold (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .code_in   (code_in),
    .in_valid  (in_valid),
    .idx       (idx2),
    .out_valid (out_valid2),
    .code_err  (code_err2),
    .step_err  (step_err2),
    .locked    (locked2),
    .sticky_err(sticky_err2),
    .wrap_cnt  (wrap_cnt2),
    .err_cnt   (err_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       v;
    logic [3:0] code;
    logic [2:0] idx;
    logic       ov;
    logic       ce;
    logic       se;
    logic       lk;
    logic       st;
    logic [7:0] ec;
    logic [7:0] wc;
  } vec_t;

  vec_t       vecs[27];
  logic [3:0] lut[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, take the edge, and leave time at edge+1.
  task automatic apply(input logic clr, input logic v, input logic [3:0] c);
    clear    = clr;
    in_valid = v;
    code_in  = c;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
  endtask

  function automatic vec_t mk(input logic clr, input logic v, input logic [3:0] c,
                              input logic [2:0] i, input logic ov, input logic ce,
                              input logic se, input logic lk, input logic st,
                              input logic [7:0] ec, input logic [7:0] wc);
    vec_t r;
    r.clr = clr; r.v = v; r.code = c; r.idx = i; r.ov = ov; r.ce = ce;
    r.se = se; r.lk = lk; r.st = st; r.ec = ec; r.wc = wc;
    return r;
  endfunction

  initial begin
    lut[0] = 4'b0000; lut[1] = 4'b0001; lut[2] = 4'b0011; lut[3] = 4'b0111;
    lut[4] = 4'b1111; lut[5] = 4'b1110; lut[6] = 4'b1100; lut[7] = 4'b1000;

    //               clr   v     code     idx  ov ce se lk st ec wc
    // Lock from 7 through the wrap to 3.
    vecs[0]  = mk(1'b0, 1'b1, 4'b1000, 3'd7, 1, 0, 0, 0, 0, 8'd0, 8'd0);
    vecs[1]  = mk(1'b0, 1'b1, 4'b0000, 3'd0, 1, 0, 0, 0, 0, 8'd0, 8'd0);
    vecs[2]  = mk(1'b0, 1'b1, 4'b0001, 3'd1, 1, 0, 0, 0, 0, 8'd0, 8'd0);
    vecs[3]  = mk(1'b0, 1'b1, 4'b0011, 3'd2, 1, 0, 0, 0, 0, 8'd0, 8'd0);
    vecs[4]  = mk(1'b0, 1'b1, 4'b0111, 3'd3, 1, 0, 0, 1, 0, 8'd0, 8'd0);
    // Gap with garbage on code_in, hold, gap, +1 step.
    vecs[5]  = mk(1'b0, 1'b0, 4'b0101, 3'd3, 0, 0, 0, 1, 0, 8'd0, 8'd0);
    vecs[6]  = mk(1'b0, 1'b1, 4'b0111, 3'd3, 1, 0, 0, 1, 0, 8'd0, 8'd0);
    vecs[7]  = mk(1'b0, 1'b0, 4'b0000, 3'd3, 0, 0, 0, 1, 0, 8'd0, 8'd0);
    vecs[8]  = mk(1'b0, 1'b1, 4'b1111, 3'd4, 1, 0, 0, 1, 0, 8'd0, 8'd0);
    // Illegal while locked, then illegal again from IDLE.
    vecs[9]  = mk(1'b0, 1'b1, 4'b0101, 3'd4, 1, 1, 0, 0, 1, 8'd1, 8'd0);
    vecs[10] = mk(1'b0, 1'b1, 4'b0101, 3'd4, 1, 1, 0, 0, 1, 8'd2, 8'd0);
    // Re-lock from 1; the 7->0 while locked bumps wrap_cnt.
    vecs[11] = mk(1'b0, 1'b1, 4'b0001, 3'd1, 1, 0, 0, 0, 1, 8'd2, 8'd0);
    vecs[12] = mk(1'b0, 1'b1, 4'b0011, 3'd2, 1, 0, 0, 0, 1, 8'd2, 8'd0);
    vecs[13] = mk(1'b0, 1'b1, 4'b0111, 3'd3, 1, 0, 0, 0, 1, 8'd2, 8'd0);
    vecs[14] = mk(1'b0, 1'b1, 4'b1111, 3'd4, 1, 0, 0, 0, 1, 8'd2, 8'd0);
    vecs[15] = mk(1'b0, 1'b1, 4'b1110, 3'd5, 1, 0, 0, 1, 1, 8'd2, 8'd0);
    vecs[16] = mk(1'b0, 1'b1, 4'b1100, 3'd6, 1, 0, 0, 1, 1, 8'd2, 8'd0);
    vecs[17] = mk(1'b0, 1'b1, 4'b1000, 3'd7, 1, 0, 0, 1, 1, 8'd2, 8'd0);
    vecs[18] = mk(1'b0, 1'b1, 4'b0000, 3'd0, 1, 0, 0, 1, 1, 8'd2, 8'd1);
    vecs[19] = mk(1'b0, 1'b1, 4'b0001, 3'd1, 1, 0, 0, 1, 1, 8'd2, 8'd1);
    vecs[20] = mk(1'b0, 1'b1, 4'b0011, 3'd2, 1, 0, 0, 1, 1, 8'd2, 8'd1);
    // Skip 2->4 while locked, then four +1 steps relock; 7->0 in TRACK no wrap.
    vecs[21] = mk(1'b0, 1'b1, 4'b1111, 3'd4, 1, 0, 1, 0, 1, 8'd3, 8'd1);
    vecs[22] = mk(1'b0, 1'b1, 4'b1110, 3'd5, 1, 0, 0, 0, 1, 8'd3, 8'd1);
    vecs[23] = mk(1'b0, 1'b1, 4'b1100, 3'd6, 1, 0, 0, 0, 1, 8'd3, 8'd1);
    vecs[24] = mk(1'b0, 1'b1, 4'b1000, 3'd7, 1, 0, 0, 0, 1, 8'd3, 8'd1);
    vecs[25] = mk(1'b0, 1'b1, 4'b0000, 3'd0, 1, 0, 0, 1, 1, 8'd3, 8'd1);
    // Clear with an illegal sample: no pulses, counters zero, idx holds.
    vecs[26] = mk(1'b1, 1'b1, 4'b0101, 3'd0, 0, 0, 0, 0, 0, 8'd0, 8'd0);

    rst      = 1'b1;
    clear    = 1'b0;
    in_valid = 1'b0;
    code_in  = 4'b0000;

    // Reset state, sampled while rst is still asserted.
    #12;
    check("rst_idx",       32'(idx),        32'd0);
    check("rst_out_valid", 32'(out_valid),  32'd0);
    check("rst_code_err",  32'(code_err),   32'd0);
    check("rst_step_err",  32'(step_err),   32'd0);
    check("rst_locked",    32'(locked),     32'd0);
    check("rst_sticky",    32'(sticky_err), 32'd0);
    check("rst_wrap_cnt",  32'(wrap_cnt),   32'd0);
    check("rst_err_cnt",   32'(err_cnt),    32'd0);
    #1 rst = 1'b0;

    for (int i = 0; i < 27; i++) begin
      apply(vecs[i].clr, vecs[i].v, vecs[i].code);
      check($sformatf("row%0d_idx", i),       32'(idx),        32'(vecs[i].idx));
      check($sformatf("row%0d_out_valid", i), 32'(out_valid),  32'(vecs[i].ov));
      check($sformatf("row%0d_code_err", i),  32'(code_err),   32'(vecs[i].ce));
      check($sformatf("row%0d_step_err", i),  32'(step_err),   32'(vecs[i].se));
      check($sformatf("row%0d_locked", i),    32'(locked),     32'(vecs[i].lk));
      check($sformatf("row%0d_sticky", i),    32'(sticky_err), 32'(vecs[i].st));
      check($sformatf("row%0d_err_cnt", i),   32'(err_cnt),    32'(vecs[i].ec));
      check($sformatf("row%0d_wrap_cnt", i),  32'(wrap_cnt),   32'(vecs[i].wc));
    end

    // err_cnt saturates at 255 while the pulse keeps firing.
    for (int i = 0; i < 260; i++) apply(1'b0, 1'b1, 4'b0101);
    check("sat_err_cnt",  32'(err_cnt),    32'd255);
    check("sat_code_err", 32'(code_err),   32'd1);
    check("sat_sticky",   32'(sticky_err), 32'd1);
    check("sat_idx",      32'(idx),        32'd0);
    apply(1'b1, 1'b0, 4'b0000);
    check("sat_clear_err_cnt", 32'(err_cnt), 32'd0);

    // Lock at 4, then 16 full laps of the 8 codes.
    for (int i = 0; i <= 4; i++) apply(1'b0, 1'b1, lut[i]);
    check("wrap_pre_locked", 32'(locked), 32'd1);
    for (int k = 0; k < 128; k++) apply(1'b0, 1'b1, lut[(5 + k) % 8]);
    check("wrap_wrap_cnt", 32'(wrap_cnt),   32'd16);
    check("wrap_err_cnt",  32'(err_cnt),    32'd0);
    check("wrap_sticky",   32'(sticky_err), 32'd0);
    check("wrap_locked",   32'(locked),     32'd1);
    check("wrap_idx",      32'(idx),        32'd4);

    // Gap then repeat of 1111: a hold for one instance, an error for the other.
    apply(1'b0, 1'b0, 4'b1111);
    check("gap_nohold_locked", 32'(locked2), 32'd1);
    check("gap_out_valid",     32'(out_valid), 32'd0);
    apply(1'b0, 1'b1, 4'b1111);
    check("hold_step_err",        32'(step_err),  32'd0);
    check("hold_locked",          32'(locked),    32'd1);
    check("nohold_step_err",      32'(step_err2), 32'd1);
    check("nohold_code_err",      32'(code_err2), 32'd0);
    check("nohold_locked",        32'(locked2),   32'd0);
    check("nohold_idx",           32'(idx2),      32'd4);
    check("nohold_err_cnt",       32'(err_cnt2),  32'd1);

    // Async reset between edges while locked.
    #3 rst = 1'b1;
    #1;
    check("arst_idx",       32'(idx),        32'd0);
    check("arst_out_valid", 32'(out_valid),  32'd0);
    check("arst_locked",    32'(locked),     32'd0);
    check("arst_wrap_cnt",  32'(wrap_cnt),   32'd0);
    check("arst_err_cnt",   32'(err_cnt),    32'd0);
    check("arst_sticky",    32'(sticky_err), 32'd0);
    check("arst_nohold_sticky", 32'(sticky_err2), 32'd0);
    #2 rst = 1'b0;

    // Fresh legal sample plus four +1 steps before lock returns.
    apply(1'b0, 1'b1, 4'b0001);
    check("relock0_idx",    32'(idx),    32'd1);
    check("relock0_locked", 32'(locked), 32'd0);
    apply(1'b0, 1'b1, 4'b0011);
    apply(1'b0, 1'b1, 4'b0111);
    apply(1'b0, 1'b1, 4'b1111);
    check("relock3_locked", 32'(locked), 32'd0);
    apply(1'b0, 1'b1, 4'b1110);
    check("relock4_locked", 32'(locked), 32'd1);
    check("relock4_idx",    32'(idx),    32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
